clock_set_ctrl: RTL

Mode and set controller for the HH:MM:SS time counter.
- Gates the 1 Hz tick into the counter.
- Sequences user editing of the time (hours, then minutes, then seconds) and commits it with a one-cycle parallel load.
- Holds a settable HH:MM alarm and raises a ring output.
- Runs on the fast system clock; buttons arrive as debounced single-cycle pulses.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/clock_set_ctrl_if.sv | 37 +++
 rtl/wrap_inc.sv | 15 +
 rtl/clock_set_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS clock set/alarm controller.
package clock_pkg;

    localparam int unsigned HW  = 5;
    localparam int unsigned MSW = 6;

    localparam logic [HW-1:0]  HH_MAX = 5'd23;
    localparam logic [MSW-1:0] MS_MAX = 6'd59;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StSetHh  = 3'd1,
        StSetMm  = 3'd2,
        StSetSs  = 3'd3,
        StCommit = 3'd4,
        StAlmHh  = 3'd5,
        StAlmMm  = 3'd6
    } state_e;

    // States where the time is frozen and the user is editing a field
    function automatic logic is_edit(state_e s);
        return (s == StSetHh) || (s == StSetMm) || (s == StSetSs) ||
               (s == StAlmHh) || (s == StAlmMm);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bus between the set controller, the user buttons and the time counter.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic           tick;
    logic           btn_mode;
    logic           btn_inc;
    logic           btn_alarm;
    logic           alarm_en;
    logic [HW-1:0]  cur_hh;
    logic [MSW-1:0] cur_mm;
    logic [MSW-1:0] cur_ss;

    logic           tick_out;
    logic           ld;
    logic [HW-1:0]  ld_hh;
    logic [MSW-1:0] ld_mm;
    logic [MSW-1:0] ld_ss;
    logic [HW-1:0]  disp_hh;
    logic [MSW-1:0] disp_mm;
    logic [MSW-1:0] disp_ss;
    logic [2:0]     state;
    logic           ring;

    // Driver side: buttons, tick source and the live counter value
    modport master (
        output tick, btn_mode, btn_inc, btn_alarm, alarm_en, cur_hh, cur_mm, cur_ss,
        input  tick_out, ld, ld_hh, ld_mm, ld_ss, disp_hh, disp_mm, disp_ss, state, ring
    );

    // Controller side
    modport slave (
        input  tick, btn_mode, btn_inc, btn_alarm, alarm_en, cur_hh, cur_mm, cur_ss,
        output tick_out, ld, ld_hh, ld_mm, ld_ss, disp_hh, disp_mm, disp_ss, state, ring
    );

endinterface

// File: rtl/wrap_inc.sv
// Modulo incrementer for one time field: returns 0 once the field maximum is reached.
module wrap_inc #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] i_val,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_val
);

    // Roll over to zero at the maximum, otherwise count up
    always_comb begin
        o_val = (i_val == i_max) ? '0 : i_val + W'(1);
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller: gates the 1 Hz tick, sequences time and alarm editing,
// commits edits with a one-cycle load and drives the alarm ring output.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned RING_SECS    = 30,
    parameter int unsigned EDIT_TIMEOUT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    clock_set_ctrl_if.slave  bus
);

    localparam int unsigned TW = $clog2(EDIT_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(RING_SECS + 1);

    state_e         r_state, w_state_d;
    logic [HW-1:0]  r_edit_hh, w_edit_hh_d, r_alm_hh, w_alm_hh_d, w_hh_inc;
    logic [MSW-1:0] r_edit_mm, w_edit_mm_d, r_alm_mm, w_alm_mm_d, w_mm_inc;
    logic [MSW-1:0] r_edit_ss, w_edit_ss_d, w_ss_inc;
    logic [TW-1:0]  r_to_cnt, w_to_cnt_d;
    logic [RW-1:0]  r_ring_cnt, w_ring_cnt_d;
    logic           r_ring, w_ring_d;
    logic           r_match_d;

    logic w_in_edit, w_timed_out, w_any_btn, w_enter_edit;
    logic w_match, w_ring_set, w_ring_expire, w_ring_clr;

    wrap_inc #(.W(HW))  u_inc_hh (.i_val(r_edit_hh), .i_max(HH_MAX), .o_val(w_hh_inc));
    wrap_inc #(.W(MSW)) u_inc_mm (.i_val(r_edit_mm), .i_max(MS_MAX), .o_val(w_mm_inc));
    wrap_inc #(.W(MSW)) u_inc_ss (.i_val(r_edit_ss), .i_max(MS_MAX), .o_val(w_ss_inc));

    // Shared decode of edit status, timeout and button activity
    always_comb begin
        w_in_edit    = is_edit(r_state);
        w_timed_out  = w_in_edit && (r_to_cnt == TW'(EDIT_TIMEOUT));
        w_any_btn    = bus.btn_mode | bus.btn_inc | bus.btn_alarm;
        w_enter_edit = is_edit(w_state_d) && (w_state_d != r_state);
    end

    // Next-state, edit field and alarm register update; btn_mode beats btn_inc
    always_comb begin
        w_state_d   = r_state;
        w_edit_hh_d = r_edit_hh;
        w_edit_mm_d = r_edit_mm;
        w_edit_ss_d = r_edit_ss;
        w_alm_hh_d  = r_alm_hh;
        w_alm_mm_d  = r_alm_mm;
        if (w_timed_out) begin
            w_state_d = StRun;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (bus.btn_mode) begin
                        w_edit_hh_d = bus.cur_hh;
                        w_edit_mm_d = bus.cur_mm;
                        w_edit_ss_d = bus.cur_ss;
                        w_state_d   = StSetHh;
                    end else if (bus.btn_alarm && !r_ring) begin
                        w_edit_hh_d = r_alm_hh;
                        w_edit_mm_d = r_alm_mm;
                        w_edit_ss_d = '0;
                        w_state_d   = StAlmHh;
                    end
                end
                StSetHh: begin
                    if (bus.btn_mode)     w_state_d   = StSetMm;
                    else if (bus.btn_inc) w_edit_hh_d = w_hh_inc;
                end
                StSetMm: begin
                    if (bus.btn_mode)     w_state_d   = StSetSs;
                    else if (bus.btn_inc) w_edit_mm_d = w_mm_inc;
                end
                StSetSs: begin
                    if (bus.btn_mode)     w_state_d   = StCommit;
                    else if (bus.btn_inc) w_edit_ss_d = w_ss_inc;
                end
                StCommit: begin
                    w_state_d = StRun;
                end
                StAlmHh: begin
                    if (bus.btn_mode)     w_state_d   = StAlmMm;
                    else if (bus.btn_inc) w_edit_hh_d = w_hh_inc;
                end
                StAlmMm: begin
                    if (bus.btn_mode) begin
                        w_alm_hh_d = r_edit_hh;
                        w_alm_mm_d = r_edit_mm;
                        w_state_d  = StRun;
                    end else if (bus.btn_inc) begin
                        w_edit_mm_d = w_mm_inc;
                    end
                end
                default: w_state_d = StRun;
            endcase
        end
    end

    // Edit inactivity counter; holds its value on a timeout return
    always_comb begin
        w_to_cnt_d = r_to_cnt;
        if (w_timed_out) begin
            w_to_cnt_d = r_to_cnt;
        end else if (w_any_btn || w_enter_edit) begin
            w_to_cnt_d = '0;
        end else if (w_in_edit && bus.tick) begin
            w_to_cnt_d = r_to_cnt + TW'(1);
        end
    end

    // Alarm match edge detect and ring set/clear; clear beats set
    always_comb begin
        w_match       = bus.alarm_en && (bus.cur_hh == r_alm_hh) &&
                        (bus.cur_mm == r_alm_mm) && (bus.cur_ss == '0);
        w_ring_set    = w_match && !r_match_d && (r_state == StRun);
        w_ring_expire = r_ring && bus.tick && (r_ring_cnt == RW'(RING_SECS - 1));
        w_ring_clr    = bus.btn_alarm || !bus.alarm_en || w_ring_expire || w_enter_edit;
        w_ring_d      = r_ring;
        w_ring_cnt_d  = r_ring_cnt;
        if (w_ring_clr) begin
            w_ring_d = 1'b0;
        end else if (w_ring_set) begin
            w_ring_d     = 1'b1;
            w_ring_cnt_d = '0;
        end else if (r_ring && bus.tick) begin
            w_ring_cnt_d = r_ring_cnt + RW'(1);
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StRun;
            r_edit_hh  <= '0;
            r_edit_mm  <= '0;
            r_edit_ss  <= '0;
            r_alm_hh   <= '0;
            r_alm_mm   <= '0;
            r_to_cnt   <= '0;
            r_ring_cnt <= '0;
            r_ring     <= 1'b0;
            r_match_d  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_edit_hh  <= w_edit_hh_d;
            r_edit_mm  <= w_edit_mm_d;
            r_edit_ss  <= w_edit_ss_d;
            r_alm_hh   <= w_alm_hh_d;
            r_alm_mm   <= w_alm_mm_d;
            r_to_cnt   <= w_to_cnt_d;
            r_ring_cnt <= w_ring_cnt_d;
            r_ring     <= w_ring_d;
            r_match_d  <= w_match;
        end
    end

    // Outputs: tick only passes in RUN; display shows live time in RUN, edit fields otherwise
    always_comb begin
        bus.tick_out = bus.tick && (r_state == StRun);
        bus.ld       = (r_state == StCommit);
        bus.ld_hh    = r_edit_hh;
        bus.ld_mm    = r_edit_mm;
        bus.ld_ss    = r_edit_ss;
        bus.state    = r_state;
        bus.ring     = r_ring;
        if (r_state == StRun) begin
            bus.disp_hh = bus.cur_hh;
            bus.disp_mm = bus.cur_mm;
            bus.disp_ss = bus.cur_ss;
        end else begin
            bus.disp_hh = r_edit_hh;
            bus.disp_mm = r_edit_mm;
            bus.disp_ss = (r_state == StAlmHh || r_state == StAlmMm) ? '0 : r_edit_ss;
        end
    end

endmodule
